// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-extended datapath: sequences fetch, decode,
// execute, memory and writeback, handshakes on mem_ready and traps on illegal opcodes.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE    = 6'h00,
  parameter logic [5:0] OP_LW       = 6'h23,
  parameter logic [5:0] OP_SW       = 6'h2B,
  parameter logic [5:0] OP_BEQ      = 6'h04,
  parameter logic [5:0] FUNCT_BALRZ = 6'h16,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4 into PC on mem_ready
  // DECODE   | branch target into ALUOut, dispatch on opcode/funct
  // EXEC_R   | R-type ALU operation
  // WB_R     | write R-type result to rd
  // ADDR     | effective address for lw/sw
  // MEM_RD   | data read, wait for mem_ready
  // WB_MEM   | write loaded data to rt
  // MEM_WR   | data write, wait for mem_ready
  // BRANCH   | beq compare, take branch on zero
  // BALRZ    | branch to rs and link PC+4 into rd when rs-rt is zero
  // ILLEGAL  | trapped, held until reset
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_WB_MEM  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRANCH  = 4'd8,
    S_BALRZ   = 4'd9,
    S_ILLEGAL = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic             trap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;
  logic             pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ILLEGAL) trap_q <= 1'b1;
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_inc     = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    pc_src      = 2'b00;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b01;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_RTYPE)
          state_d = (funct == FUNCT_BALRZ) ? S_BALRZ : S_EXEC_R;
        else if (opcode == OP_LW || opcode == OP_SW)
          state_d = S_ADDR;
        else if (opcode == OP_BEQ)
          state_d = S_BRANCH;
        else
          state_d = S_ILLEGAL;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
        cnt_inc     = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord       = 1'b1;
        mem_read_c = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_to_reg  = 2'b01;
        reg_write_c = 1'b1;
        cnt_inc     = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          cnt_inc = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write_c = zero;
        cnt_inc    = 1'b1;
        state_d    = S_FETCH;
      end
      S_BALRZ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        // PC already holds PC+4 from FETCH, so the link value is the PC itself
        if (zero) begin
          pc_write_c  = 1'b1;
          pc_src      = 2'b10;
          reg_dst     = 1'b1;
          mem_to_reg  = 2'b10;
          reg_write_c = 1'b1;
        end
        cnt_inc = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  // Strobes are gated by rst_n so a reset mid-access drops them the same cycle
  assign pc_write  = pc_write_c  & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign mem_read  = mem_read_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign trap      = trap_q;
  assign instr_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second 2-bit-counter instance shares the
// stimulus to exercise instr_cnt wraparound.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_dst, reg_write, alu_src_a, trap;
  logic [1:0]  pc_src, mem_to_reg, alu_src_b, alu_op;
  logic [31:0] instr_cnt;
  logic [3:0]  state;

  logic        w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write, w_reg_dst, w_reg_write;
  logic        w_alu_src_a, w_trap;
  logic [1:0]  w_pc_src, w_mem_to_reg, w_alu_src_b, w_alu_op;
  logic [1:0]  w_instr_cnt;
  logic [3:0]  w_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap), .instr_cnt(instr_cnt),
    .state(state)
  );

  multicycle_ctrl #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(w_pc_write), .pc_src(w_pc_src), .ir_write(w_ir_write),
    .iord(w_iord), .mem_read(w_mem_read), .mem_write(w_mem_write), .reg_dst(w_reg_dst),
    .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write), .alu_src_a(w_alu_src_a),
    .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .trap(w_trap), .instr_cnt(w_instr_cnt),
    .state(w_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, then let inputs/outputs settle before checking
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (rst_n === 1'b1) chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    cyc(); cyc();
    chk("rst_state", state, 32'd0);
    chk("rst_memrd_gated", mem_read, 32'd0);
    chk("rst_trap", trap, 32'd0);
    chk("rst_cnt", instr_cnt, 32'd0);
    rst_n = 1'b1; #1;

    // lw: 0,1,4,5,6
    opcode = 6'h23; #1;
    chk("lw_f_state", state, 32'd0);
    chk("lw_f_strobes", {mem_read, ir_write, pc_write, iord, alu_src_b}, {4'b1110, 2'b01});
    cyc();
    chk("lw_d_state", state, 32'd1);
    chk("lw_d_srcb", alu_src_b, 32'd3);
    cyc();
    chk("lw_addr", {state, alu_src_a, alu_src_b, alu_op}, {4'd4, 1'b1, 2'b10, 2'b00});
    cyc();
    chk("lw_memrd", {state, iord, mem_read, mem_write}, {4'd5, 3'b110});
    cyc();
    chk("lw_wb", {state, reg_write, mem_to_reg, reg_dst}, {4'd6, 1'b1, 2'b01, 1'b0});
    chk("lw_cnt_before", instr_cnt, 32'd0);
    cyc();
    chk("lw_done", state, 32'd0);
    chk("lw_cnt_after", instr_cnt, 32'd1);

    // sw with mem_ready low 3 cycles in MEM_WR
    opcode = 6'h2B;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait", {state, mem_write, mem_read, iord}, {4'd7, 3'b101});
      cyc();
    end
    mem_ready = 1'b1; #1;
    chk("sw_last", {state, mem_write}, {4'd7, 1'b1});
    chk("sw_cnt_hold", instr_cnt, 32'd1);
    cyc();
    chk("sw_done", state, 32'd0);
    chk("sw_cnt", instr_cnt, 32'd2);

    // beq taken
    opcode = 6'h04; zero = 1'b1;
    cyc(); cyc();
    chk("beq_t", {state, pc_write, pc_src, alu_op, reg_write}, {4'd8, 1'b1, 2'b01, 2'b01, 1'b0});
    cyc();
    chk("beq_t_done", {state, instr_cnt[3:0]}, {4'd0, 4'd3});

    // beq not taken, one wait cycle in FETCH
    zero = 1'b0; mem_ready = 1'b0; #1;
    chk("fetch_wait", {state, mem_read, ir_write, pc_write}, {4'd0, 3'b100});
    cyc();
    mem_ready = 1'b1; #1;
    chk("fetch_wait_state", state, 32'd0);
    cyc(); cyc();
    chk("beq_nt", {state, pc_write}, {4'd8, 1'b0});
    cyc();
    chk("beq_nt_done", {state, instr_cnt[3:0]}, {4'd0, 4'd4});

    // balrz taken
    opcode = 6'h00; funct = 6'h16; zero = 1'b1;
    cyc(); cyc();
    chk("balrz_t", {state, pc_write, pc_src, reg_write, mem_to_reg, reg_dst},
        {4'd9, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1});
    cyc();
    chk("balrz_t_done", {state, instr_cnt[3:0]}, {4'd0, 4'd5});

    // balrz not taken
    zero = 1'b0;
    cyc(); cyc();
    chk("balrz_nt", {state, pc_write, pc_src, reg_write, mem_to_reg}, {4'd9, 1'b0, 2'b00, 1'b0, 2'b00});
    cyc();
    chk("balrz_nt_done", {state, instr_cnt[3:0]}, {4'd0, 4'd6});

    // R-type add
    funct = 6'h20;
    cyc(); cyc();
    chk("r_exec", {state, alu_src_a, alu_src_b, alu_op}, {4'd2, 1'b1, 2'b00, 2'b10});
    cyc();
    chk("r_wb", {state, reg_write, reg_dst, mem_to_reg}, {4'd3, 1'b1, 1'b1, 2'b00});
    cyc();
    chk("r_cnt", instr_cnt, 32'd7);
    chk("wrap_cnt_3", w_instr_cnt, 32'd3);

    // one more retirement wraps the 2-bit counter
    opcode = 6'h04;
    cyc(); cyc(); cyc();
    chk("cnt_8", instr_cnt, 32'd8);
    chk("wrap_cnt_0", w_instr_cnt, 32'd0);

    // reset mid MEM_WR
    opcode = 6'h2B; mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0; #1;
    chk("rstwr_pre", {state, mem_write}, {4'd7, 1'b1});
    rst_n = 1'b0; #1;
    chk("rstwr_gated", {mem_write, mem_read, reg_write, pc_write, ir_write}, 32'd0);
    cyc();
    chk("rstwr_state", state, 32'd0);
    chk("rstwr_cnt", instr_cnt, 32'd0);
    rst_n = 1'b1; mem_ready = 1'b1;

    // beq then illegal opcode
    opcode = 6'h04;
    cyc(); cyc(); cyc();
    chk("pre_ill_cnt", instr_cnt, 32'd1);
    opcode = 6'h3F;
    cyc();
    chk("ill_decode", {state, trap}, {4'd1, 1'b0});
    cyc();
    chk("ill_enter", {state, mem_read, mem_write, reg_write, pc_write}, {4'd10, 4'b0000});
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("ill_hold", {state, trap, mem_read, pc_write, ir_write}, {4'd10, 1'b1, 3'b000});
    end
    chk("ill_cnt", instr_cnt, 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; #1;
    chk("ill_rst", {state, trap}, {4'd0, 1'b0});
    chk("ill_rst_cnt", instr_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
